// File: rtl/rtc_pkg.sv
// ============================================================================
// rtc_pkg : shared types, timing defaults and RTC address map for the burst
//           sequencer.                                      Rev 1.0
// ============================================================================
`default_nettype none

package rtc_pkg;

  localparam int BUS_W = 8;

  localparam int T_SU_DEF  = 2;
  localparam int T_PW_DEF  = 4;
  localparam int T_H_DEF   = 2;
  localparam int T_GAP_DEF = 2;

  localparam logic [BUS_W-1:0] ADDR_SEC  = 8'h21;
  localparam logic [BUS_W-1:0] ADDR_MIN  = 8'h22;
  localparam logic [BUS_W-1:0] ADDR_HOUR = 8'h23;
  localparam logic [BUS_W-1:0] ADDR_DAY  = 8'h24;
  localparam logic [BUS_W-1:0] ADDR_MON  = 8'h25;
  localparam logic [BUS_W-1:0] ADDR_YEAR = 8'h26;
  localparam logic [BUS_W-1:0] ADDR_CMD  = 8'hF0;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR_SU = 4'd1,
    S_ADDR_PW = 4'd2,
    S_ADDR_H  = 4'd3,
    S_GAP_A   = 4'd4,
    S_DATA_SU = 4'd5,
    S_DATA_PW = 4'd6,
    S_DATA_H  = 4'd7,
    S_GAP_D   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    STEP_NONE = 3'd0,
    STEP_SU   = 3'd1,
    STEP_PW   = 3'd2,
    STEP_H    = 3'd3,
    STEP_GAP  = 3'd4
  } step_t;

  function automatic step_t step_of(input state_t s);
    case (s)
      S_ADDR_SU, S_DATA_SU: return STEP_SU;
      S_ADDR_PW, S_DATA_PW: return STEP_PW;
      S_ADDR_H,  S_DATA_H:  return STEP_H;
      S_GAP_A,   S_GAP_D:   return STEP_GAP;
      default:              return STEP_NONE;
    endcase
  endfunction

  function automatic logic is_data_state(input state_t s);
    return (s == S_DATA_SU) || (s == S_DATA_PW) || (s == S_DATA_H);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_bus_phase.sv
// ============================================================================
// rtc_bus_phase : phase timer and registered strobe generator for one
//                 address or data phase of an RTC access.   Rev 1.0
// ============================================================================
`default_nettype none

module rtc_bus_phase
  import rtc_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_H   = T_H_DEF,
  parameter int T_GAP = T_GAP_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enter,
  input  step_t step,
  input  logic  is_data,
  input  logic  is_read,
  output logic  tmr_zero,
  output logic  cs,
  output logic  rd,
  output logic  wr,
  output logic  a_d,
  output logic  dq_oe
);

  localparam int TW = 8;

  logic [TW-1:0] tmr_q;
  logic [TW-1:0] load_val;
  logic          cs_nx, rd_nx, wr_nx, a_d_nx, oe_nx;

  // Strobes are decoded from the step being entered and then registered,
  // so every edge lines up with a state boundary and cannot glitch.
  always_comb begin
    load_val = '0;
    cs_nx    = 1'b1;
    rd_nx    = 1'b1;
    wr_nx    = 1'b1;
    a_d_nx   = 1'b1;
    oe_nx    = 1'b0;
    case (step)
      STEP_SU:  load_val = TW'(T_SU - 1);
      STEP_PW:  load_val = TW'(T_PW - 1);
      STEP_H:   load_val = TW'(T_H - 1);
      STEP_GAP: load_val = TW'(T_GAP - 1);
      default:  load_val = '0;
    endcase
    if (step == STEP_SU || step == STEP_PW || step == STEP_H) begin
      cs_nx  = 1'b0;
      a_d_nx = is_data;
      oe_nx  = !(is_data && is_read);
      if (step == STEP_PW) begin
        if (is_data && is_read) rd_nx = 1'b0;
        else                    wr_nx = 1'b0;
      end
    end
  end

  assign tmr_zero = (tmr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      cs    <= 1'b1;
      rd    <= 1'b1;
      wr    <= 1'b1;
      a_d   <= 1'b1;
      dq_oe <= 1'b0;
    end else begin
      if (enter)              tmr_q <= load_val;
      else if (tmr_q != '0)   tmr_q <= tmr_q - 1'b1;
      cs    <= cs_nx;
      rd    <= rd_nx;
      wr    <= wr_nx;
      a_d   <= a_d_nx;
      dq_oe <= oe_nx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rtc_burst_seq.sv
// ============================================================================
// rtc_burst_seq : moves a block of RTC time/date registers between register
//                 RAM and the RTC parallel bus, optional commit. Rev 1.0
// ============================================================================
`default_nettype none

module rtc_burst_seq
  import rtc_pkg::*;
#(
  parameter int               N_REGS    = 6,
  parameter logic [BUS_W-1:0] ADDR_BASE = ADDR_SEC,
  parameter logic [BUS_W-1:0] CMD_ADDR  = ADDR_CMD,
  parameter bit               COMMIT_EN = 1'b1,
  parameter int               T_SU      = T_SU_DEF,
  parameter int               T_PW      = T_PW_DEF,
  parameter int               T_H       = T_H_DEF,
  parameter int               T_GAP     = T_GAP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             a_d,
  output logic             cs,
  output logic             rd,
  output logic             wr,
  output logic [BUS_W-1:0] dq_out,
  output logic             dq_oe,
  input  logic [BUS_W-1:0] dq_in,
  output logic [3:0]       ram_idx,
  output logic             ram_rd_en,
  output logic             ram_wr_en,
  output logic [BUS_W-1:0] ram_wdata,
  input  logic [BUS_W-1:0] ram_rdata
);

  state_t           state_q, next_state;
  logic             accept, enter, tmr_zero;
  logic             mode_q, mode_nx;
  logic [3:0]       k_q, k_nx, last_idx;
  logic             commit_nx, rd_pend;
  logic [BUS_W-1:0] wbyte_q, dq_out_nx;
  logic             ram_rd_en_nx, ram_wr_en_nx;
  step_t            step_nx;
  logic             data_nx;

  assign last_idx = (mode_q && COMMIT_EN) ? 4'(N_REGS) : 4'(N_REGS - 1);

  // DONE also accepts start so back-to-back bursts leave busy low one cycle.
  always_comb begin
    next_state = state_q;
    accept     = 1'b0;
    case (state_q)
      S_IDLE:    if (start) begin next_state = S_ADDR_SU; accept = 1'b1; end
      S_ADDR_SU: if (tmr_zero) next_state = S_ADDR_PW;
      S_ADDR_PW: if (tmr_zero) next_state = S_ADDR_H;
      S_ADDR_H:  if (tmr_zero) next_state = S_GAP_A;
      S_GAP_A:   if (tmr_zero) next_state = S_DATA_SU;
      S_DATA_SU: if (tmr_zero) next_state = S_DATA_PW;
      S_DATA_PW: if (tmr_zero) next_state = S_DATA_H;
      S_DATA_H:  if (tmr_zero) next_state = S_GAP_D;
      S_GAP_D:   if (tmr_zero) next_state = (k_q == last_idx) ? S_DONE : S_ADDR_SU;
      S_DONE: begin
        if (start) begin next_state = S_ADDR_SU; accept = 1'b1; end
        else             next_state = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  assign enter   = (next_state != state_q);
  assign step_nx = step_of(next_state);
  assign data_nx = is_data_state(next_state);

  always_comb begin
    mode_nx = accept ? mode : mode_q;
    k_nx    = k_q;
    if (accept)
      k_nx = '0;
    else if (state_q == S_GAP_D && next_state == S_ADDR_SU)
      k_nx = k_q + 4'd1;
    commit_nx = mode_nx && COMMIT_EN && (k_nx == 4'(N_REGS));
    dq_out_nx = '0;
    case (next_state)
      S_ADDR_SU, S_ADDR_PW, S_ADDR_H:
        dq_out_nx = commit_nx ? CMD_ADDR : ADDR_BASE + {4'd0, k_nx};
      S_DATA_SU, S_DATA_PW, S_DATA_H:
        if (mode_nx) dq_out_nx = wbyte_q;
      default: dq_out_nx = '0;
    endcase
    ram_rd_en_nx = mode_nx && (next_state == S_ADDR_SU) && (state_q != S_ADDR_SU);
    ram_wr_en_nx = !mode_q && (state_q == S_DATA_PW) && (next_state == S_DATA_H);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      k_q       <= '0;
      rd_pend   <= 1'b0;
      wbyte_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dq_out    <= '0;
      ram_idx   <= '0;
      ram_rd_en <= 1'b0;
      ram_wr_en <= 1'b0;
      ram_wdata <= '0;
    end else begin
      mode_q    <= mode_nx;
      k_q       <= k_nx;
      rd_pend   <= ram_rd_en;
      if (rd_pend) wbyte_q <= ram_rdata;
      busy      <= (next_state != S_IDLE) && (next_state != S_DONE);
      done      <= (next_state == S_DONE);
      dq_out    <= dq_out_nx;
      ram_idx   <= k_nx;
      ram_rd_en <= ram_rd_en_nx;
      ram_wr_en <= ram_wr_en_nx;
      // dq_in is taken on the last strobe cycle, when the RTC data is settled.
      if (ram_wr_en_nx) ram_wdata <= dq_in;
    end
  end

  rtc_bus_phase #(
    .T_SU  (T_SU),
    .T_PW  (T_PW),
    .T_H   (T_H),
    .T_GAP (T_GAP)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .enter    (enter),
    .step     (step_nx),
    .is_data  (data_nx),
    .is_read  (!mode_nx),
    .tmr_zero (tmr_zero),
    .cs       (cs),
    .rd       (rd),
    .wr       (wr),
    .a_d      (a_d),
    .dq_oe    (dq_oe)
  );

endmodule

`default_nettype wire

// File: tb/tb_rtc_burst_seq.sv
// ============================================================================
// tb_rtc_burst_seq : directed bench with bus-level RTC and RAM models.
//                                                           Rev 1.0
// ============================================================================
`default_nettype none

module tb_rtc_burst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, mode;
  logic       busy, done, a_d, cs, rd, wr, dq_oe, ram_rd_en, ram_wr_en;
  logic [7:0] dq_out, dq_in, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic [3:0] ram_idx;

  logic       start_s, mode_s;
  logic       busy_s, done_s, a_d_s, cs_s, rd_s, wr_s, dq_oe_s, ram_rd_en_s, ram_wr_en_s;
  logic [7:0] dq_out_s, ram_wdata_s;
  logic [7:0] ram_rdata_s = 8'h00;
  logic [3:0] ram_idx_s;

  int vectors = 0;
  int miscompares = 0;

  rtc_burst_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
    .ram_idx(ram_idx), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  rtc_burst_seq #(
    .N_REGS(1), .COMMIT_EN(1'b0), .T_SU(1), .T_PW(1), .T_H(1), .T_GAP(1)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .start(start_s), .mode(mode_s), .busy(busy_s), .done(done_s),
    .a_d(a_d_s), .cs(cs_s), .rd(rd_s), .wr(wr_s), .dq_out(dq_out_s), .dq_oe(dq_oe_s),
    .dq_in(8'h00), .ram_idx(ram_idx_s), .ram_rd_en(ram_rd_en_s), .ram_wr_en(ram_wr_en_s),
    .ram_wdata(ram_wdata_s), .ram_rdata(ram_rdata_s)
  );

  // Register RAM models: read data one cycle after the strobe.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= ram[ram_idx];
    if (ram_wr_en) ram[ram_idx] <= ram_wdata;
    if (ram_rd_en_s) ram_rdata_s <= 8'hA5 ^ {4'd0, ram_idx_s};
  end

  // RTC bus monitor: logs addresses/data on falling wr, returns 0x10+k on reads.
  int         busy_cnt = 0, done_cnt = 0, n_addr = 0, n_data = 0, n_rd = 0;
  logic [7:0] addr_log [16];
  logic [7:0] data_log [16];
  logic [7:0] addr_lat = 8'h00;
  logic       prev_wr = 1'b1, prev_rd = 1'b1;
  assign dq_in = addr_lat + 8'hEF;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (!cs && !wr && prev_wr) begin
      if (!a_d) begin
        addr_lat = dq_out;
        if (n_addr < 16) addr_log[n_addr] = dq_out;
        n_addr++;
      end else begin
        if (n_data < 16) data_log[n_data] = dq_out;
        n_data++;
      end
    end
    if (!cs && a_d && !rd && prev_rd) n_rd++;
    prev_wr = wr;
    prev_rd = rd;
  end

  int         s_busy = 0, s_done = 0, s_wrlow = 0;
  logic [7:0] s_addr = 8'h00, s_data = 8'h00;
  always @(negedge clk) begin
    if (busy_s) s_busy++;
    if (done_s) s_done++;
    if (!wr_s) begin
      s_wrlow++;
      if (!a_d_s) s_addr = dq_out_s;
      else        s_data = dq_out_s;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    busy_cnt = 0; done_cnt = 0; n_addr = 0; n_data = 0; n_rd = 0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic check_write_burst(input string tag);
    logic [7:0] ram_init [7] = '{8'h30, 8'h45, 8'h12, 8'h07, 8'h09, 8'h16, 8'h00};
    logic [7:0] ea;
    chk({tag, "_busy_cycles"}, busy_cnt, 140);
    chk({tag, "_n_addr"}, n_addr, 7);
    chk({tag, "_n_data"}, n_data, 7);
    chk({tag, "_n_rd"}, n_rd, 0);
    for (int i = 0; i < 7; i++) begin
      ea = (i < 6) ? 8'(8'h21 + i) : 8'hF0;
      chk($sformatf("%s_addr%0d", tag, i), addr_log[i], ea);
      chk($sformatf("%s_data%0d", tag, i), data_log[i], ram_init[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; start_s = 1'b0; mode_s = 1'b0;
    repeat (3) step();

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ctl", {a_d, cs, rd, wr}, 4'hF);
    chk("rst_dq_oe", dq_oe, 1'b0);
    chk("rst_dq_out", dq_out, 8'h00);
    chk("rst_ram_en", {ram_rd_en, ram_wr_en}, 2'b00);
    chk("rst_ram_idx", ram_idx, 4'h0);
    chk("rst_ram_wdata", ram_wdata, 8'h00);

    rst_n = 1'b1;
    repeat (2) step();

    // Minimal configuration: one 8-cycle access, one-cycle wr per phase.
    mode_s = 1'b1; start_s = 1'b1;
    step();
    start_s = 1'b0;
    chk("s_busy_latency", busy_s, 1'b1);
    n = 0;
    while (!done_s && n < 50) begin step(); n++; end
    chk("s_done_seen", done_s, 1'b1);
    chk("s_busy_at_done", busy_s, 1'b0);
    chk("s_busy_cycles", s_busy, 8);
    chk("s_wr_low_cycles", s_wrlow, 2);
    chk("s_addr", s_addr, 8'h21);
    chk("s_data", s_data, 8'hA5);

    // Write burst with commit.
    ram[0] = 8'h30; ram[1] = 8'h45; ram[2] = 8'h12; ram[3] = 8'h07;
    ram[4] = 8'h09; ram[5] = 8'h16; ram[6] = 8'h00;
    clear_logs();
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("w1_busy_latency", busy, 1'b1);
    chk("w1_first_addr", {cs, a_d, wr, dq_oe, dq_out}, {4'b0011, 8'h21});
    chk("w1_fetch", {ram_rd_en, ram_idx}, {1'b1, 4'h0});
    wait_done(400, "w1");
    chk("w1_busy_at_done", busy, 1'b0);
    check_write_burst("w1");

    // Back-to-back: start given in the done cycle, with a flipped mid-burst start.
    clear_logs();
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy_restart", busy, 1'b1);
    repeat (50) step();
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    wait_done(400, "w2");
    check_write_burst("w2");
    chk("w2_done_count", done_cnt, 1);
    step();
    chk("w2_done_pulse_end", {done, busy}, 2'b00);

    // Read burst abandoned by reset during DATA_PW of access 3.
    clear_logs();
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(n_addr == 4 && !rd) && n < 200) begin step(); n++; end
    chk("ab_reach_data_pw", {n_addr[7:0], rd}, {8'd4, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("ab_strobes_high", {cs, rd, wr}, 3'b111);
    chk("ab_dq_oe_low", dq_oe, 1'b0);
    chk("ab_busy_low", busy, 1'b0);
    repeat (5) step();
    chk("ab_no_done", done_cnt, 0);
    rst_n = 1'b1;
    step();

    // Clean read burst after reset.
    for (int i = 0; i < 6; i++) ram[i] = 8'hEE;
    clear_logs();
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(300, "rd");
    chk("rd_busy_cycles", busy_cnt, 120);
    chk("rd_n_addr", n_addr, 6);
    chk("rd_last_addr", addr_log[5], 8'h26);
    chk("rd_n_rd", n_rd, 6);
    chk("rd_n_wdata", n_data, 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rd_ram%0d", i), ram[i], 8'(8'h10 + i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
